// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one shared signed MAC, runtime-writable coefficients, rounded/saturated output.
// Sample accepted at edge E pulses out_valid after edge E+TAPS+1; in_ready only in IDLE, so the source holds samples while busy.
module fir_mac_serial #(
  parameter int DW = 16,
  parameter int CW = 8,
  parameter int TAPS = 5,
  parameter int SHIFT = 11,
  parameter int OW = 24,
  parameter logic [TAPS*CW-1:0] COEF_INIT = {8'sd2, 8'sd7, 8'sd8, 8'sd7, 8'sd2}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_wdata,
  output logic                     busy,
  output logic                     out_valid,
  output logic [OW-1:0]            out_data,
  output logic                     out_sat
);

  localparam int IW = $clog2(TAPS);
  localparam int AW = DW + CW + IW;
  localparam int PW = DW + CW;
  // Output stage works one bit wider than both the accumulator and the output so
  // the rounding add cannot wrap and the clip limits are always representable.
  localparam int EW = ((AW + 1 > OW) ? AW + 1 : OW) + 1;
  localparam logic [IW-1:0] LAST   = IW'(TAPS - 1);
  localparam logic [IW:0]   TAPS_W = (IW + 1)'(TAPS);
  localparam logic signed [EW-1:0] RND  = EW'(1) <<< (SHIFT - 1);
  localparam logic signed [EW-1:0] OMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   x_q [TAPS];
  logic signed [DW-1:0]   x_d [TAPS];
  logic signed [CW-1:0]   c_q [TAPS];
  logic signed [CW-1:0]   c_d [TAPS];
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [OW-1:0]          out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;

  logic signed [DW-1:0]   x_sel;
  logic signed [CW-1:0]   c_sel;
  logic signed [PW-1:0]   prod;
  logic signed [EW-1:0]   acc_ext, rsum, rsh;

  assign x_sel   = x_q[idx_q];
  assign c_sel   = c_q[idx_q];
  assign prod    = $signed({{CW{x_sel[DW-1]}}, x_sel}) * $signed({{DW{c_sel[CW-1]}}, c_sel});
  assign acc_ext = {{(EW-AW){acc_q[AW-1]}}, acc_q};
  assign rsum    = acc_ext + RND;
  assign rsh     = rsum >>> SHIFT;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (coef_we && ({1'b0, coef_addr} < TAPS_W)) begin
          c_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + $signed({{IW{prod[PW-1]}}, prod});
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (rsh > OMAX) begin
          out_data_d = OMAX[OW-1:0];
          out_sat_d  = 1'b1;
        end else if (rsh < OMIN) begin
          out_data_d = OMIN[OW-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = rsh[OW-1:0];
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= COEF_INIT[k*CW +: CW];
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= x_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
